// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial two's-complement subtractor computing a - b. A single
//            full-subtractor cell is stepped LSB-first over WIDTH cycles.
//            A start/busy/done handshake frames each operation. The
//            difference and the borrow, zero and signed-overflow flags are
//            registered outputs.
// Ports    : clk    - clock, rising edge active
//            rst_n  - asynchronous active-low reset
//            start  - operation request, sampled only while idle
//            a, b   - minuend / subtrahend, captured on the accepting edge
//            busy   - high while bits are being shifted
//            done   - one-cycle pulse when a new result is written
//            diff   - a - b mod 2^WIDTH
//            borrow - 1 iff unsigned a < b
//            zero   - 1 iff diff == 0
//            ovf    - signed overflow of a - b
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_c;
    // Operand sign bits are shifted out of r_ra/r_rb, so keep them for ovf.
    logic             r_a_msb;
    logic             r_b_msb;

    logic             r_diff_valid_unused;

    logic             w_accept;
    logic             w_last;
    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_c_next;
    logic [WIDTH-1:0] w_sr_next;

    // ------------------------------------------------------------------
    // Full-subtractor cell and shift-in of the result bit
    // ------------------------------------------------------------------
    always_comb begin
        w_x       = r_ra[0];
        w_y       = r_rb[0];
        w_d       = w_x ^ w_y ^ r_c;
        w_c_next  = (~w_x & w_y) | (~(w_x ^ w_y) & r_c);
        w_sr_next = {w_d, r_sr[WIDTH-1:1]};
        w_accept  = (r_state == S_IDLE) && start;
        w_last    = (r_state == S_SHIFT) && (r_cnt == c_LAST_BIT);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (r_cnt == c_LAST_BIT) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand shift registers, counter and borrow chain
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ra    <= '0;
            r_rb    <= '0;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_c     <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (w_accept) begin
            r_ra    <= a;
            r_rb    <= b;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_c     <= 1'b0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (r_state == S_SHIFT) begin
            r_ra  <= {1'b0, r_ra[WIDTH-1:1]};
            r_rb  <= {1'b0, r_rb[WIDTH-1:1]};
            r_sr  <= w_sr_next;
            r_cnt <= r_cnt + 1'b1;
            r_c   <= w_c_next;
        end
    end

    // ------------------------------------------------------------------
    // Result registers: only touched on the final shift edge, so they
    // hold the previous result for the whole SHIFT phase.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff   <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else if (w_last) begin
            diff   <= w_sr_next;
            borrow <= w_c_next;
            zero   <= (w_sr_next == '0);
            ovf    <= (r_a_msb != r_b_msb) && (w_sr_next[WIDTH-1] != r_a_msb);
        end
    end

    // Tracks that at least one result has been produced since reset; kept
    // as a debug observation point only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff_valid_unused <= 1'b0;
        end else if (w_last) begin
            r_diff_valid_unused <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor (WIDTH = 8). Expected
//            results are computed from the applied operands and queued when
//            a request is driven, then popped when done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
    logic             ovf;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             zero;
        logic             ovf;
    } exp_t;

    exp_t             q_exp[$];
    logic [WIDTH-1:0] last_diff;
    int               n_checks;
    int               n_fails;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: widen to WIDTH+1 bits so the top bit is the unsigned borrow.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t        e;
        logic [WIDTH:0] full;
        full     = {1'b0, x} - {1'b0, y};
        e.diff   = full[WIDTH-1:0];
        e.borrow = full[WIDTH];
        e.zero   = (e.diff == '0);
        e.ovf    = (x[WIDTH-1] != y[WIDTH-1]) && (e.diff[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    // Waits (bounded) for done, checking busy length, result hold during
    // SHIFT, the popped expected result and the single-cycle done pulse.
    task automatic wait_result(input bit drop_start, input bit chg,
                               input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb);
        int   nbusy;
        bit   got;
        exp_t e;
        nbusy = 0;
        got   = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else if (busy) begin
                nbusy++;
                if (drop_start) start = 1'b0;
                check("hold_diff", 32'(diff), 32'(last_diff));
                if (chg && nbusy == 3) begin
                    a = na;
                    b = nb;
                end
            end
        end
        check("done_seen", 32'(got), 32'd1);
        if (got) begin
            check("busy_len", 32'(nbusy), 32'(WIDTH));
            check("busy_at_done", 32'(busy), 32'd0);
            check("queue_nonempty", 32'(q_exp.size() > 0), 32'd1);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                check("diff", 32'(diff), 32'(e.diff));
                check("borrow", 32'(borrow), 32'(e.borrow));
                check("zero", 32'(zero), 32'(e.zero));
                check("ovf", 32'(ovf), 32'(e.ovf));
                last_diff = e.diff;
            end
            @(negedge clk);
            check("done_pulse_len", 32'(done), 32'd0);
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        q_exp.push_back(model(x, y));
        wait_result(1'b1, 1'b0, '0, '0);
    endtask

    initial begin
        bit seen_done;
        n_checks  = 0;
        n_fails   = 0;
        last_diff = '0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({busy, done, diff, borrow, zero, ovf}), 32'd0);
        rst_n = 1'b1;

        // Directed arithmetic cases
        run_op(8'h50, 8'h20);   // 0x30
        run_op(8'h20, 8'h50);   // 0xD0, borrow
        run_op(8'h80, 8'h01);   // 0x7F, signed overflow
        run_op(8'h33, 8'h33);   // zero

        // start held high; operands change mid-SHIFT
        @(negedge clk);
        a     = 8'h12;
        b     = 8'h34;
        start = 1'b1;
        q_exp.push_back(model(8'h12, 8'h34));
        q_exp.push_back(model(8'hFF, 8'h01));
        wait_result(1'b0, 1'b1, 8'hFF, 8'h01);
        wait_result(1'b1, 1'b0, '0, '0);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        a     = 8'hA5;
        b     = 8'h3C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({busy, done, diff, borrow, zero, ovf}), 32'd0);
        last_diff = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("no_done_after_abort", 32'(seen_done), 32'd0);

        // Fresh operation after reset: 0x7F - 0xFF = 0x80, borrow, ovf
        run_op(8'h7F, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes A − B, the inverse operation of the team's combinational ripple adder.
- Uses one full-subtractor cell iterated LSB-first over WIDTH cycles, trading latency for area in the small-tile design.
- Start/busy/done handshake; registered difference plus borrow, zero and signed-overflow flags.
- Sits beside the adder in the top-level wrapper, fed from dedicated and bidirectional input pins.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend, captured on the accepting edge.
- b  input  WIDTH  subtrahend, captured on the accepting edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when a new result is written.
- diff  output  WIDTH  registered a − b mod 2^WIDTH.
- borrow  output  1  registered borrow-out; 1 iff unsigned a < b.
- zero  output  1  registered; 1 iff diff == 0.
- ovf  output  1  registered signed overflow.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - busy, done, diff, borrow, zero and ovf = 0.
  - Operand shift registers, bit counter and borrow register cleared.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - On an edge with start=1, latch a→ra and b→rb, clear the borrow register and counter, and go to SHIFT.
  - start=0 → stay in IDLE.
- SHIFT: each edge performs one bit step, with x=ra[0], y=rb[0], c=borrow register:
  - d = x^y^c.
  - c' = (~x&y) | (~(x^y)&c).
  - d shifts into the MSB of the internal result register sr; ra and rb shift right; counter increments.
  - On the WIDTH-th SHIFT edge:
    - diff ← final sr, borrow ← final c'.
    - zero ← (final sr == 0).
    - ovf ← (a_latched[MSB] != b_latched[MSB]) && (final sr[MSB] != a_latched[MSB]).
    - Go to DONE.
  - Keep a copy of the latched MSBs for the ovf calculation.
- DONE: done=1 for exactly this one cycle, then unconditionally go to IDLE.
- Latency:
  - start accepted at edge E0.
  - busy=1 from E0 until edge E_WIDTH.
  - Outputs updated and done=1 in the cycle after E_WIDTH.
  - Next start accepted at edge E_WIDTH+2 at the earliest; throughput is 1 op per WIDTH+2 cycles.
- Output hold: diff and all flags keep their previous result during SHIFT and change only on the WIDTH-th shift edge.
- Input changes:
  - start while in SHIFT or DONE is ignored; it is not queued.
  - Changes on a and b after the accepting edge have no effect.
- Reset mid-operation: an immediate abort with all registers at their reset values; no done pulse; a start after reset release begins a fresh operation.
- Wrap-around: the result is modulo 2^WIDTH; borrow carries the unsigned underflow.

Test Plan:
- Reset: rst_n=0 during SHIFT → busy=0, done=0, diff=0x00, all flags 0 immediately (asynchronous), no done afterwards.
- Basic subtraction: a=0x50, b=0x20, start for 1 cycle → busy for 8 cycles, then done pulse with diff=0x30, borrow=0, zero=0, ovf=0.
- Underflow: a=0x20, b=0x50 → diff=0xD0, borrow=1, ovf=0.
- Signed overflow: a=0x80, b=0x01 → diff=0x7F, borrow=0, ovf=1.
- Equal operands: a=0x33, b=0x33 → diff=0x00, zero=1, borrow=0.
- Handshake: start held high continuously, with a/b changed to 0xFF/0x01 mid-SHIFT →
  - first result is from the originally latched operands;
  - no restart while busy;
  - diff holds its old value until done;
  - the second op begins on the IDLE edge after DONE with the new operands → diff=0xFE.
